// File: rtl/trace_pkg.sv
// Shared definitions for the retire-trace unit: record layout, word count, FSM encoding.
// Build option: TRACE_CYCLE_STAMP_EN appends a cycle-stamp word W4 to each record.
package trace_pkg;

`ifdef TRACE_CYCLE_STAMP_EN
  localparam int NW = 5;
`else
  localparam int NW = 4;
`endif

  localparam int WORD_W       = 32;
  localparam int REC_W        = NW * WORD_W;
  localparam int W2_WE_BIT    = 31;
  localparam int W2_WADDR_MSB = 4;
  localparam int W2_WADDR_LSB = 0;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    W0   = 3'd1,
    W1   = 3'd2,
    W2   = 3'd3,
    W3   = 3'd4
`ifdef TRACE_CYCLE_STAMP_EN
    ,
    W4   = 3'd5
`endif
  } state_t;

`ifdef TRACE_CYCLE_STAMP_EN
  localparam state_t LAST_ST = W4;
`else
  localparam state_t LAST_ST = W3;
`endif

  function automatic logic [WORD_W-1:0] rec_word(input logic [REC_W-1:0] rec,
                                                 input logic [2:0]       idx);
    return rec[idx*WORD_W +: WORD_W];
  endfunction

  // A write to $0 is architecturally a no-op, so it is recorded as no-write.
  function automatic logic [WORD_W-1:0] w2_pack(input logic       we_eff,
                                                input logic [4:0] waddr);
    logic [WORD_W-1:0] w;
    w = 32'd0;
    w[W2_WE_BIT] = we_eff;
    w[W2_WADDR_MSB:W2_WADDR_LSB] = waddr;
    return w;
  endfunction

endpackage

// File: rtl/trace_capture_if.sv
// Word stream from the trace unit to its consumer (host, UART or compare block).
interface trace_capture_if;
  logic        t_valid;
  logic        t_ready;
  logic [31:0] t_data;
  logic        t_last;

  modport master (output t_valid, output t_data, output t_last, input t_ready);
  modport slave  (input t_valid, input t_data, input t_last, output t_ready);
endinterface

// File: rtl/trace_fifo.sv
// Synchronous record FIFO; an extra pointer bit separates full from empty.
module trace_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign do_push_s = push && !full && !flush;
  assign do_pop_s  = pop && !empty;
  assign dout      = mem_r[rd_ptr_r[AW-1:0]];

  // Storage array; pointers gate every read so contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

  // Pointer update; flush empties the FIFO ahead of any traffic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else if (flush) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/trace_capture.sv
// Retire-trace unit: captures each retired instruction into a FIFO and streams it as NW words.
// Build option: TRACE_CYCLE_STAMP_EN adds a free-running cycle stamp as word W4.
module trace_capture
  import trace_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int MAX_RECORDS = 153,
  parameter int DROP_W      = 16
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic              retire_valid,
  input  logic [31:0]       retire_pc,
  input  logic [31:0]       retire_instr,
  input  logic              rf_we,
  input  logic [4:0]        rf_waddr,
  input  logic [31:0]       rf_wdata,
  trace_capture_if.master   tx,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              done,
  output logic [15:0]       rec_cnt
);

  logic [REC_W-1:0]  rec_in_s;
  logic [REC_W-1:0]  fifo_dout_s;
  logic [REC_W-1:0]  rec_r;
  logic              we_eff_s;
  logic              push_s;
  logic              wr_s;
  logic              drop_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              fifo_pop_s;
  logic              hs_s;
  state_t            state_r;
  state_t            state_nxt_s;
  logic              t_valid_r;
  logic              t_valid_nxt_s;
  logic [31:0]       t_data_r;
  logic [31:0]       t_data_nxt_s;
  logic              t_last_r;
  logic              t_last_nxt_s;
  logic [15:0]       rec_cnt_r;
  logic [DROP_W-1:0] drop_cnt_r;
  logic              overflow_r;
  logic              done_r;
`ifdef TRACE_CYCLE_STAMP_EN
  logic [31:0]       cyc_r;
`endif

  assign we_eff_s = rf_we && (rf_waddr != 5'd0);
  assign push_s   = retire_valid && enable && !done_r && !clear;
  // full is the pre-edge value: a push onto a full FIFO drops even if a pop happens now.
  assign wr_s     = push_s && !fifo_full_s;
  assign drop_s   = push_s && fifo_full_s;
  assign hs_s     = t_valid_r && tx.t_ready;

  // Assemble the record from the commit information of the retiring instruction.
  always_comb begin
    rec_in_s = {REC_W{1'b0}};
    rec_in_s[0*WORD_W +: WORD_W] = retire_pc;
    rec_in_s[1*WORD_W +: WORD_W] = retire_instr;
    rec_in_s[2*WORD_W +: WORD_W] = w2_pack(we_eff_s, rf_waddr);
    rec_in_s[3*WORD_W +: WORD_W] = we_eff_s ? rf_wdata : 32'd0;
`ifdef TRACE_CYCLE_STAMP_EN
    rec_in_s[4*WORD_W +: WORD_W] = cyc_r;
`endif
  end

  trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_in),
    .rst_n (reset),
    .flush (clear),
    .push  (wr_s),
    .pop   (fifo_pop_s),
    .din   (rec_in_s),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Serializer next-state and next-output logic; a fetch pops the head into rec_r.
  always_comb begin
    state_nxt_s   = state_r;
    t_valid_nxt_s = t_valid_r;
    t_data_nxt_s  = t_data_r;
    t_last_nxt_s  = t_last_r;
    fifo_pop_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) begin
          fifo_pop_s    = 1'b1;
          state_nxt_s   = W0;
          t_valid_nxt_s = 1'b1;
          t_data_nxt_s  = rec_word(fifo_dout_s, 3'd0);
          t_last_nxt_s  = 1'b0;
        end else begin
          t_valid_nxt_s = 1'b0;
          t_data_nxt_s  = 32'd0;
          t_last_nxt_s  = 1'b0;
        end
      end
      default: begin
        if (state_r > LAST_ST) begin
          state_nxt_s   = IDLE;
          t_valid_nxt_s = 1'b0;
          t_data_nxt_s  = 32'd0;
          t_last_nxt_s  = 1'b0;
        end else if (!hs_s) begin
          state_nxt_s = state_r;
        end else if (state_r == LAST_ST) begin
          if (!fifo_empty_s) begin
            fifo_pop_s    = 1'b1;
            state_nxt_s   = W0;
            t_valid_nxt_s = 1'b1;
            t_data_nxt_s  = rec_word(fifo_dout_s, 3'd0);
            t_last_nxt_s  = 1'b0;
          end else begin
            state_nxt_s   = IDLE;
            t_valid_nxt_s = 1'b0;
            t_data_nxt_s  = 32'd0;
            t_last_nxt_s  = 1'b0;
          end
        end else begin
          // State Wk carries code k+1, which is also the index of the next word.
          state_nxt_s  = state_t'(3'(state_r) + 3'd1);
          t_data_nxt_s = rec_word(rec_r, 3'(state_r));
          t_last_nxt_s = ((3'(state_r) + 3'd1) == 3'(LAST_ST));
        end
      end
    endcase
  end

  // Serializer state, registered stream outputs and latched record.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      t_valid_r <= 1'b0;
      t_data_r  <= 32'd0;
      t_last_r  <= 1'b0;
      rec_r     <= {REC_W{1'b0}};
    end else if (clear) begin
      state_r   <= IDLE;
      t_valid_r <= 1'b0;
      t_data_r  <= 32'd0;
      t_last_r  <= 1'b0;
      rec_r     <= {REC_W{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      t_valid_r <= t_valid_nxt_s;
      t_data_r  <= t_data_nxt_s;
      t_last_r  <= t_last_nxt_s;
      if (fifo_pop_s) begin
        rec_r <= fifo_dout_s;
      end
    end
  end

  // Accepted/dropped record accounting; done freezes capture at MAX_RECORDS.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      rec_cnt_r  <= 16'd0;
      drop_cnt_r <= {DROP_W{1'b0}};
      overflow_r <= 1'b0;
      done_r     <= 1'b0;
    end else if (clear) begin
      rec_cnt_r  <= 16'd0;
      drop_cnt_r <= {DROP_W{1'b0}};
      overflow_r <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      if (wr_s) begin
        rec_cnt_r <= rec_cnt_r + 16'd1;
        if ((rec_cnt_r + 16'd1) == 16'(MAX_RECORDS)) begin
          done_r <= 1'b1;
        end
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
        if (drop_cnt_r != {DROP_W{1'b1}}) begin
          drop_cnt_r <= drop_cnt_r + {{(DROP_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

`ifdef TRACE_CYCLE_STAMP_EN
  // Free-running cycle counter sampled into W4 at the push edge.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      cyc_r <= 32'd0;
    end else if (clear) begin
      cyc_r <= 32'd0;
    end else begin
      cyc_r <= cyc_r + 32'd1;
    end
  end
`endif

  assign tx.t_valid = t_valid_r;
  assign tx.t_data  = t_data_r;
  assign tx.t_last  = t_last_r;
  assign overflow   = overflow_r;
  assign drop_cnt   = drop_cnt_r;
  assign done       = done_r;
  assign rec_cnt    = rec_cnt_r;

endmodule

// File: tb/tb_trace_capture.sv
// Directed, scoreboard-checked bench for trace_capture.
module tb_trace_capture;
  import trace_pkg::*;

  logic        clk_in = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        clear = 1'b0;
  logic        retire_valid = 1'b0;
  logic [31:0] retire_pc = 32'd0;
  logic [31:0] retire_instr = 32'd0;
  logic        rf_we = 1'b0;
  logic [4:0]  rf_waddr = 5'd0;
  logic [31:0] rf_wdata = 32'd0;
  logic        overflow;
  logic [15:0] drop_cnt;
  logic        done;
  logic [15:0] rec_cnt;

  trace_capture_if tx();

  trace_capture #(.DEPTH(8), .MAX_RECORDS(153), .DROP_W(16)) dut (
    .clk_in(clk_in), .reset(reset), .enable(enable), .clear(clear),
    .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_instr(retire_instr),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .tx(tx),
    .overflow(overflow), .drop_cnt(drop_cnt), .done(done), .rec_cnt(rec_cnt)
  );

  always #5 clk_in = ~clk_in;

  typedef struct { logic [31:0] data; logic last; } exp_t;
  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference cycle counter: value at the push edge goes into W4.
  logic [31:0] cyc_model;
  always @(posedge clk_in or negedge reset) begin
    if (!reset) cyc_model <= 32'd0;
    else if (clear) cyc_model <= 32'd0;
    else cyc_model <= cyc_model + 32'd1;
  end

  logic        pv = 1'b0, pr = 1'b0, pl = 1'b0, pclr = 1'b0;
  logic [31:0] pd = 32'd0;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr, input logic we,
                          input logic [4:0] waddr, input logic [31:0] wdata);
    logic [31:0] w[5];
    logic we_eff;
    we_eff = we && (waddr != 5'd0);
    w[0] = pc;
    w[1] = instr;
    w[2] = {we_eff, 26'd0, waddr};
    w[3] = we_eff ? wdata : 32'd0;
    w[4] = cyc_model;
    for (int i = 0; i < NW; i++) exp_q.push_back('{w[i], (i == NW - 1)});
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] instr, input logic we,
                        input logic [4:0] waddr, input logic [31:0] wdata, input bit cap);
    retire_valid = 1'b1;
    retire_pc = pc; retire_instr = instr; rf_we = we; rf_waddr = waddr; rf_wdata = wdata;
    if (cap) push_exp(pc, instr, we, waddr, wdata);
    step();
    retire_valid = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tx.t_valid) && n < maxc) begin
      step();
      n++;
    end
    checks++;
    assert (exp_q.size() == 0 && !tx.t_valid) else begin
      errors++;
      $error("FAIL drain: observed %0d words pending expected 0", exp_q.size());
    end
  endtask

  // Stream monitor: hold-stability while stalled, and scoreboard compare on every handshake.
  task automatic mon_sample();
    exp_t e;
    if (reset) begin
      if (pv && !pr && !pclr) begin
        checks++;
        assert (tx.t_valid === 1'b1 && tx.t_data === pd && tx.t_last === pl) else begin
          errors++;
          $error("FAIL hold: observed v=%b d=%h l=%b expected v=1 d=%h l=%b",
                 tx.t_valid, tx.t_data, tx.t_last, pd, pl);
        end
      end
      if (tx.t_valid && tx.t_ready) begin
        checks++;
        assert (exp_q.size() > 0) else begin
          errors++;
          $error("FAIL stream_extra: observed word %h expected no word", tx.t_data);
        end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checks++;
          assert (tx.t_data === e.data && tx.t_last === e.last) else begin
            errors++;
            $error("FAIL stream_word: observed %h last=%b expected %h last=%b",
                   tx.t_data, tx.t_last, e.data, e.last);
          end
        end
      end
    end
    pv = tx.t_valid && reset;
    pr = tx.t_ready;
    pd = tx.t_data;
    pl = tx.t_last;
    pclr = clear;
  endtask

  initial forever begin
    @(negedge clk_in);
    mon_sample();
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tx.t_ready = 1'b0;
    #1 reset = 1'b0;
    #2;
    chk("rst_valid", 32'(tx.t_valid), 32'd0);
    chk("rst_data", tx.t_data, 32'd0);
    chk("rst_last", 32'(tx.t_last), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rec", 32'(rec_cnt), 32'd0);
    step(); step();
    reset = 1'b1;
    tx.t_ready = 1'b1;
    step();

    // Single record: latency and consecutive words
    retire(32'h00400000, 32'h3c010040, 1'b1, 5'd1, 32'h00400000, 1'b1);
    chk("lat_pre", 32'(tx.t_valid), 32'd0);
    step();
    chk("lat_valid", 32'(tx.t_valid), 32'd1);
    chk("w0", tx.t_data, 32'h00400000);
    step(); chk("w1", tx.t_data, 32'h3c010040);
    step(); chk("w2", tx.t_data, 32'h80000001);
    chk("w2_last", 32'(tx.t_last), 32'd0);
    step(); chk("w3", tx.t_data, 32'h00400000);
    chk("w3_last", 32'(tx.t_last), 32'(NW == 4));
    drain(20);
    chk("rec_1", 32'(rec_cnt), 32'd1);

    // $0 write, no-write record, disabled capture
    retire(32'h00400004, 32'h20001234, 1'b1, 5'd0, 32'h00001234, 1'b1);
    retire(32'h00400008, 32'h00000000, 1'b0, 5'd7, 32'hdeadbeef, 1'b1);
    drain(40);
    enable = 1'b0;
    retire(32'h0040000c, 32'h11111111, 1'b1, 5'd3, 32'h5, 1'b0);
    enable = 1'b1;
    step();
    chk("en_off_rec", 32'(rec_cnt), 32'd3);
    chk("en_off_valid", 32'(tx.t_valid), 32'd0);

    // Backpressure at W1, then back-to-back records
    retire(32'h00400100, 32'haaaa0001, 1'b1, 5'd2, 32'h0000aaaa, 1'b1);
    retire(32'h00400104, 32'hbbbb0002, 1'b1, 5'd3, 32'h0000bbbb, 1'b1);
    step();
    tx.t_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_w1", tx.t_data, 32'haaaa0001);
    end
    tx.t_ready = 1'b1;
    step(); step();
    chk("bp_last", 32'(tx.t_last), 32'(NW == 4));
    if (NW == 5) step();
    step();
    chk("no_bubble_valid", 32'(tx.t_valid), 32'd1);
    chk("no_bubble_w0", tx.t_data, 32'h00400104);
    drain(40);

    // Overflow: one record held stalled in the serializer, then 10 retires
    tx.t_ready = 1'b0;
    retire(32'h00401000, 32'hc0000000, 1'b1, 5'd4, 32'h0, 1'b1);
    step();
    for (int i = 0; i < 10; i++)
      retire(32'h00401004 + 32'(4 * i), 32'hc0000001 + 32'(i), 1'b1, 5'd5, 32'(i), (i < 8));
    chk("ovf_drop", 32'(drop_cnt), 32'd2);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_rec", 32'(rec_cnt), 32'd14);
    chk("ovf_hold", tx.t_data, 32'h00401000);
    tx.t_ready = 1'b1;
    drain(100);

    // Clear with a concurrent retire
    clear = 1'b1;
    retire(32'h00402000, 32'h1, 1'b1, 5'd1, 32'h1, 1'b0);
    clear = 1'b0;
    chk("clr_rec", 32'(rec_cnt), 32'd0);
    chk("clr_drop", 32'(drop_cnt), 32'd0);
    chk("clr_ovf", 32'(overflow), 32'd0);
    step();
    chk("clr_no_capture", 32'(tx.t_valid), 32'd0);

    // Record limit
    for (int i = 0; i < 160; i++) begin
      retire(32'h00500000 + 32'(4 * i), 32'(i), 1'b1, 5'(i), ~32'(i), (i < 153));
      if (i == 151) begin
        chk("lim_rec_152", 32'(rec_cnt), 32'd152);
        chk("lim_done_152", 32'(done), 32'd0);
      end
      if (i == 152) chk("lim_done_153", 32'(done), 32'd1);
      repeat (3) step();
    end
    chk("lim_rec", 32'(rec_cnt), 32'd153);
    chk("lim_done", 32'(done), 32'd1);
    chk("lim_drop", 32'(drop_cnt), 32'd0);
    drain(100);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("lim_clr_rec", 32'(rec_cnt), 32'd0);
    chk("lim_clr_done", 32'(done), 32'd0);

    // Clear mid-record while stalled
    tx.t_ready = 1'b0;
    retire(32'h00600000, 32'h2, 1'b1, 5'd6, 32'h6, 1'b1);
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    exp_q.delete();
    chk("clr_mid_valid", 32'(tx.t_valid), 32'd0);
    tx.t_ready = 1'b1;
    step();
    chk("clr_mid_idle", 32'(tx.t_valid), 32'd0);

    // Asynchronous reset during W2, then a fresh record
    retire(32'h00700000, 32'h77777777, 1'b1, 5'd7, 32'h00000777, 1'b1);
    step(); step(); step();
    chk("rstmid_w2", tx.t_data, 32'h80000007);
    #1 reset = 1'b0;
    #1;
    chk("rstmid_valid", 32'(tx.t_valid), 32'd0);
    chk("rstmid_rec", 32'(rec_cnt), 32'd0);
    exp_q.delete();
    step();
    reset = 1'b1;
    retire(32'h00800000, 32'h88888888, 1'b1, 5'd8, 32'h00000888, 1'b1);
    step();
    chk("rstmid_after_w0", tx.t_data, 32'h00800000);
    drain(40);

`ifdef TRACE_CYCLE_STAMP_EN
    // Cycle stamps of retires spaced 4 cycles apart (absolute values checked by scoreboard)
    retire(32'h00900000, 32'h9, 1'b1, 5'd9, 32'h9, 1'b1);
    repeat (3) step();
    retire(32'h00900004, 32'ha, 1'b1, 5'd10, 32'ha, 1'b1);
    chk("stamp_delta", exp_q[2 * NW - 1].data - exp_q[NW - 1].data, 32'd4);
    drain(40);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trace_capture.md
Name: trace_capture

Overview:
- Retire-trace unit sitting directly downstream of the single-cycle CPU (sccomp_dataflow); consumes its per-instruction commit information.
- Records per retired instruction: PC, instruction word, register-file write (index/data).
- Buffers records in a FIFO and serializes each record as 32-bit words over a valid/ready stream to a host/UART/compare block.
- Gives a synthesizable, bounded per-instruction trace on hardware.

Parameters:
- DEPTH, 8: FIFO depth in records; power of two, ≥2.
- MAX_RECORDS, 153: records accepted after clear/reset before capture stops (0x99).
- DROP_W, 16: width of the saturating drop counter.

Ports:
- clk_in  in  1  CPU clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  capture enable; sampled each cycle.
- clear  in  1  synchronous flush and counter reset; priority over all except reset.
- retire_valid  in  1  instruction retires this cycle.
- retire_pc  in  32  PC of the retiring instruction.
- retire_instr  in  32  instruction word.
- rf_we  in  1  register-file write enable this cycle.
- rf_waddr  in  5  destination register.
- rf_wdata  in  32  write data.
- t_valid  out  1  output word valid.
- t_ready  in  1  consumer ready.
- t_data  out  32  output word.
- t_last  out  1  final word of a record.
- overflow  out  1  sticky: at least one record dropped.
- drop_cnt  out  DROP_W  dropped-record count; saturates at all-ones.
- done  out  1  MAX_RECORDS accepted.
- rec_cnt  out  16  records accepted.

Behaviour:
- Reset (reset=0, async):
  - FIFO empty; FSM IDLE.
  - All outputs 0: t_valid, t_data, t_last, overflow, drop_cnt, done, rec_cnt.
- Record format, NW words (NW=4 by default):
  - W0 = retire_pc.
  - W1 = retire_instr.
  - W2 = {we_eff, 26'd0, rf_waddr}.
  - W3 = we_eff ? rf_wdata : 0.
  - we_eff = rf_we && (rf_waddr != 0); writes to $0 are recorded as no-write.
- Push conditions, evaluated on the rising edge:
  - push = retire_valid && enable && !done && !clear.
  - If push && !full: record written to FIFO; rec_cnt+1.
  - If push && full: record dropped; drop_cnt+1 (saturating); overflow←1.
- Full/pop interaction:
  - full is the pre-edge value; a push on a full FIFO drops even if a pop occurs on the same edge.
  - Push on an empty FIFO together with an FSM fetch is legal.
- done:
  - Set on the edge where rec_cnt reaches MAX_RECORDS.
  - Afterwards retire_valid is ignored and not counted as a drop.
  - Cleared only by clear or reset.
- Serializer FSM, states IDLE, W0, W1, W2, W3:
  - IDLE → W0 when the FIFO is non-empty; head is latched into a record register and popped on the same edge.
  - Wk → Wk+1 on t_valid && t_ready.
  - Last word state → W0 if FIFO non-empty (back-to-back records, no bubble), else IDLE.
  - t_valid=1 in any Wk state; t_data is the word k of the latched record.
  - t_last=1 only in the last word state.
- Latency: a record pushed at edge N, with FIFO empty and FSM IDLE, presents W0 with t_valid=1 after edge N+1.
- Stream rules:
  - t_data and t_last are held stable while t_valid && !t_ready.
  - t_valid never drops without a handshake, except on clear or reset.
- Throughput: one word per cycle with t_ready=1; sustained capacity is 1 record per NW cycles. Faster retirement fills the FIFO, then drops.
- clear=1 at an edge:
  - FIFO emptied; FSM to IDLE; t_valid←0.
  - rec_cnt, drop_cnt, overflow, done ← 0.
  - The concurrent retire is not captured.
  - Any partially sent record is abandoned; the consumer must resynchronize on the next W0.
- Reset mid-record behaves the same as clear, but asynchronously.

Optional Feature:
- Macro: TRACE_CYCLE_STAMP_EN.
- Defined:
  - Free-running 32-bit cycle counter; reset/clear to 0; increments every clk_in; wraps.
  - Appended as W4 = counter value at the push edge.
  - NW=5; FSM gains state W4; t_last moves to W4.
  - FIFO width grows to 160 bits.
- Undefined: NW=4, no counter, no W4 state; FIFO width 128 bits.

Decomposition:
- Shared package trace_pkg holds:
  - NW (conditional on the macro).
  - FSM state encoding.
  - W2 field positions (WE bit 31, WADDR [4:0]).
  - Record width constant.
- Sub-module trace_fifo:
  - Synchronous FIFO with parameters WIDTH and DEPTH.
  - Ports: push, pop, din, dout, full, empty.
  - Pointer-based, one extra pointer bit for full/empty.
  - Async active-low reset plus sync flush.

Test Plan:
- Single record: retire pc=0x00400000, instr=0x3c010040, rf_we=1, waddr=1, wdata=0x00400000, t_ready=1 → W0..W3 = 00400000, 3c010040, 80000001, 00400000 on consecutive cycles; t_last on W3; W0 appears one cycle after the push edge.
- $0 write: waddr=0, rf_we=1, wdata=0x1234 → W2=00000000, W3=00000000.
- Backpressure: t_ready=0 for 5 cycles mid-record at W1 → t_data held at W1; no word lost or duplicated; two back-to-back records stream with no IDLE bubble.
- Overflow: DEPTH=8, t_ready=0, 10 consecutive retires → 8 stored; drop_cnt=2; overflow=1; then 8 records drain in order.
- Limit: 160 retires with t_ready=1 → rec_cnt=153; done=1; retires after done leave drop_cnt unchanged; clear → all counters 0, done=0.
- Reset/clear mid-record: assert reset low during W2 → t_valid=0 immediately (async); after release, the next retire is emitted starting at W0. With TRACE_CYCLE_STAMP_EN, W4 increases by exactly 4 between retires spaced 4 cycles apart.
